// File: rtl/pwm_capture.sv
// PWM receiver: synchronizes a PWM pin and recovers high time and rise-to-rise period,
// flagging stuck-high/stuck-low lines and off-nominal periods.
module pwm_capture #(
  parameter int PWM_INTERVAL = 1200,
  parameter int TIMEOUT      = 2 * PWM_INTERVAL,
  parameter int SYNC_STAGES  = 2,
  localparam int W  = $clog2(PWM_INTERVAL + 1),
  localparam int CW = $clog2(TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pwm_in,
  output logic [W-1:0]  duty_value,
  output logic [CW:0]   period_value,
  output logic          valid,
  output logic          stuck_high,
  output logic          stuck_low,
  output logic          period_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  localparam logic [CW-1:0] L_TIMEOUT     = CW'(TIMEOUT);
  localparam logic [CW-1:0] L_ONE         = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] L_INTERVAL_CW = CW'(PWM_INTERVAL);
  localparam logic [W-1:0]  L_INTERVAL_W  = W'(PWM_INTERVAL);
  localparam logic [CW:0]   L_NOM_PERIOD  = (CW + 1)'(PWM_INTERVAL);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_d;
  state_t                 r_state;
  logic [CW-1:0]          r_high_cnt;
  logic [CW-1:0]          r_low_cnt;
  logic [CW-1:0]          r_idle_cnt;
  logic                   r_reported;
  logic [W-1:0]           r_duty;
  logic [CW:0]            r_period;
  logic                   r_valid;
  logic                   r_stuck_high;
  logic                   r_stuck_low;
  logic                   r_period_err;

  logic                   w_s;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_timeout;
  logic [CW:0]            w_period_sum;
  logic [W-1:0]           w_duty_sat;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    sat_inc = (v >= L_TIMEOUT) ? v : (v + L_ONE);
  endfunction

  assign w_s          = r_sync[SYNC_STAGES-1];
  assign w_rise       = w_s & ~r_s_d;
  assign w_fall       = ~w_s & r_s_d;
  // A rise in the same cycle as the timeout takes precedence.
  assign w_timeout    = (r_idle_cnt == L_TIMEOUT) & ~r_reported & ~w_rise;
  assign w_period_sum = {1'b0, r_high_cnt} + {1'b0, r_low_cnt};
  assign w_duty_sat   = (r_high_cnt > L_INTERVAL_CW) ? L_INTERVAL_W : r_high_cnt[W-1:0];

  // Input synchronizer plus one-cycle delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {SYNC_STAGES{1'b0}};
      r_s_d  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pwm_in};
      r_s_d  <= w_s;
    end
  end

  // Measurement FSM, idle/timeout tracking and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_high_cnt   <= {CW{1'b0}};
      r_low_cnt    <= {CW{1'b0}};
      r_idle_cnt   <= {CW{1'b0}};
      r_reported   <= 1'b0;
      r_duty       <= {W{1'b0}};
      r_period     <= {(CW + 1){1'b0}};
      r_valid      <= 1'b0;
      r_stuck_high <= 1'b0;
      r_stuck_low  <= 1'b0;
      r_period_err <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_rise) begin
        r_idle_cnt <= {CW{1'b0}};
        r_reported <= 1'b0;
      end else begin
        r_idle_cnt <= sat_inc(r_idle_cnt);
      end

      case (r_state)
        ST_IDLE: begin
          // The partial period seen before the first rise is discarded.
          if (w_rise) begin
            r_state    <= ST_HIGH;
            r_high_cnt <= L_ONE;
            r_low_cnt  <= {CW{1'b0}};
          end
        end
        ST_HIGH: begin
          if (w_fall) begin
            r_state   <= ST_LOW;
            r_low_cnt <= L_ONE;
          end else begin
            r_high_cnt <= sat_inc(r_high_cnt);
          end
        end
        ST_LOW: begin
          if (w_rise) begin
            r_duty       <= w_duty_sat;
            r_period     <= w_period_sum;
            r_period_err <= (w_period_sum != L_NOM_PERIOD);
            r_stuck_high <= 1'b0;
            r_stuck_low  <= 1'b0;
            r_valid      <= 1'b1;
            r_high_cnt   <= L_ONE;
            r_low_cnt    <= {CW{1'b0}};
            r_state      <= ST_HIGH;
          end else begin
            r_low_cnt <= sat_inc(r_low_cnt);
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_timeout) begin
        r_duty       <= w_s ? L_INTERVAL_W : {W{1'b0}};
        r_stuck_high <= w_s;
        r_stuck_low  <= ~w_s;
        r_period     <= {(CW + 1){1'b0}};
        r_period_err <= 1'b1;
        r_valid      <= 1'b1;
        r_reported   <= 1'b1;
        r_state      <= ST_IDLE;
      end
    end
  end

  assign duty_value   = r_duty;
  assign period_value = r_period;
  assign valid        = r_valid;
  assign stuck_high   = r_stuck_high;
  assign stuck_low    = r_stuck_low;
  assign period_err   = r_period_err;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: table of PWM shapes plus stuck-line and reset sequences;
// expected results queue up as stimulus is driven and are popped on each valid pulse.
module tb_pwm_capture;

  localparam int PWM_INTERVAL = 1200;
  localparam int W  = $clog2(PWM_INTERVAL + 1);
  localparam int CW = $clog2(2 * PWM_INTERVAL + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pwm_in;
  logic [W-1:0]  duty_value;
  logic [CW:0]   period_value;
  logic          valid;
  logic          stuck_high;
  logic          stuck_low;
  logic          period_err;

  typedef struct {
    int duty;
    int period;
    bit sh;
    bit sl;
    bit perr;
  } exp_t;

  typedef struct {
    int h;
    int l;
    int duty;
    int period;
    bit perr;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[6];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_valid = 0;
  int   valid_cyc = -1;
  bit   prev_valid = 1'b0;

  pwm_capture #(.PWM_INTERVAL(PWM_INTERVAL)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pwm_in       (pwm_in),
    .duty_value   (duty_value),
    .period_value (period_value),
    .valid        (valid),
    .stuck_high   (stuck_high),
    .stuck_low    (stuck_low),
    .period_err   (period_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int duty, input int period, input bit sh, input bit sl, input bit perr);
    exp_t e;
    e.duty = duty; e.period = period; e.sh = sh; e.sl = sl; e.perr = perr;
    sb.push_back(e);
  endtask

  task automatic drive(input logic v, input int n);
    pwm_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_duty"},   int'(duty_value),   0);
    check({tag, "_period"}, int'(period_value), 0);
    check({tag, "_valid"},  int'(valid),        0);
    check({tag, "_sh"},     int'(stuck_high),   0);
    check({tag, "_sl"},     int'(stuck_low),    0);
    check({tag, "_perr"},   int'(period_err),   0);
  endtask

  // Scoreboard monitor: every valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && valid === 1'b1) begin
      exp_t e;
      n_valid++;
      valid_cyc = cyc;
      check("valid_not_back_to_back", int'(prev_valid), 0);
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got duty=%0d period=%0d expected no valid", duty_value, period_value);
      end else begin
        e = sb.pop_front();
        check("duty_value",   int'(duty_value),   e.duty);
        check("period_value", int'(period_value), e.period);
        check("stuck_high",   int'(stuck_high),   int'(e.sh));
        check("stuck_low",    int'(stuck_low),    int'(e.sl));
        check("period_err",   int'(period_err),   int'(e.perr));
      end
    end
    prev_valid = (valid === 1'b1);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    int c_rise;

    tbl[0] = '{h: 300,  l: 900,  duty: 300,  period: 1200, perr: 1'b0};
    tbl[1] = '{h: 1199, l: 1,    duty: 1199, period: 1200, perr: 1'b0};
    tbl[2] = '{h: 500,  l: 500,  duty: 500,  period: 1000, perr: 1'b1};
    tbl[3] = '{h: 1,    l: 1199, duty: 1,    period: 1200, perr: 1'b0};
    tbl[4] = '{h: 1300, l: 100,  duty: 1200, period: 1400, perr: 1'b1};
    tbl[5] = '{h: 50,   l: 70,   duty: 50,   period: 120,  perr: 1'b1};

    rst_n  = 1'b0;
    pwm_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst_n = 1'b1;
    c0 = cyc;

    // Line never toggles after reset: one stuck-low report, then silence.
    push(0, 0, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 3000);
    check("stuck_low_count", n_valid, 1);
    check("stuck_low_latency", valid_cyc - c0, 2401);

    // Table of waveforms; each period is published on the following rise.
    for (int i = 0; i < 6; i++) begin
      c_rise = cyc;
      if (i > 0) push(tbl[i-1].duty, tbl[i-1].period, 1'b0, 1'b0, tbl[i-1].perr);
      drive(1'b1, tbl[i].h);
      drive(1'b0, tbl[i].l);
      if (i > 0) check("publish_latency", valid_cyc - c_rise, 3);
    end
    check("table_valid_count", n_valid, 6);

    // Close the last period, then hold high until the stuck-high report.
    push(tbl[5].duty, tbl[5].period, 1'b0, 1'b0, tbl[5].perr);
    push(PWM_INTERVAL, 0, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 5000);
    check("stuck_high_count", n_valid, 8);
    drive(1'b0, 300);
    drive(1'b1, 300);
    drive(1'b0, 900);
    check("no_valid_after_stuck", n_valid, 8);
    push(300, 1200, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 150);
    check("recovered_valid_count", n_valid, 9);

    // Reset in the middle of a high phase clears everything at once.
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midreset");
    pwm_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b0, 200);
    drive(1'b1, 400);
    drive(1'b0, 800);
    check("no_valid_after_reset", n_valid, 9);
    push(400, 1200, 1'b0, 1'b0, 1'b0);
    c_rise = cyc;
    drive(1'b1, 50);
    check("post_reset_latency", valid_cyc - c_rise, 3);
    drive(1'b0, 100);

    check("final_valid_count", n_valid, 10);
    check("scoreboard_drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
